spi_master_clkgen: RTL and testbench

SPI_MASTER_CLKGEN -- requirements
Module: spi_master_clkgen

---
 rtl/spi_master_clkgen.sv | 79 +++++++
 tb/tb_spi_master_clkgen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_master_clkgen.sv
// SPI mode-0 serial clock generator with programmable half period (clk_div+1 cycles).
// Edge strobes fire one cycle ahead of the spi_clk transition; divider updates are deferred to IDLE.
module spi_master_clkgen (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] clk_div,
   input  logic       clk_div_valid,
   output logic       spi_clk,
   output logic       rise_edge,
   output logic       fall_edge,
   output logic       running
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t     state;
   logic [7:0] div_q;
   logic [7:0] div_pend;
   logic [7:0] cnt;
   logic       pend_vld;
   logic       at_boundary;

   // Reset masks the strobes so a reset cycle mid-RUN never leaks a trailing pulse.
   assign at_boundary = (state == RUN) && (cnt == div_q) && !rst;
   assign rise_edge   = at_boundary && !spi_clk && en;
   assign fall_edge   = at_boundary && spi_clk;
   assign running     = (state == RUN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         spi_clk  <= 1'b0;
         cnt      <= 8'd0;
         div_q    <= 8'd0;
         div_pend <= 8'd0;
         pend_vld <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A fresh strobe supersedes anything left pending from the last run.
               if (clk_div_valid) begin
                  div_q    <= clk_div;
                  pend_vld <= 1'b0;
               end else if (pend_vld) begin
                  div_q    <= div_pend;
                  pend_vld <= 1'b0;
               end
               if (en) begin
                  state <= RUN;
                  cnt   <= 8'd0;
               end
            end
            RUN: begin
               if (clk_div_valid) begin
                  div_pend <= clk_div;
                  pend_vld <= 1'b1;
               end
               if (cnt != div_q) begin
                  cnt <= cnt + 8'd1;
               end else begin
                  cnt <= 8'd0;
                  if (spi_clk)
                     spi_clk <= 1'b0;
                  else if (en)
                     spi_clk <= 1'b1;
                  else
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_clkgen.sv
module tb_spi_master_clkgen;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] clk_div;
   logic       clk_div_valid;
   logic       spi_clk;
   logic       rise_edge;
   logic       fall_edge;
   logic       running;

   spi_master_clkgen dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .clk_div       (clk_div),
      .clk_div_valid (clk_div_valid),
      .spi_clk       (spi_clk),
      .rise_edge     (rise_edge),
      .fall_edge     (fall_edge),
      .running       (running)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;
   int rq[$];
   int fq[$];
   int t0;

   // Reference: level plus countdown to the next half-period boundary.
   int m_div  = 0;
   int m_pend = -1;
   int m_left = 0;
   bit m_run  = 0;
   bit m_lvl  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      if (rst) begin
         m_div = 0; m_pend = -1; m_run = 0; m_lvl = 0; m_left = 0;
      end else if (!m_run) begin
         if (clk_div_valid) begin
            m_div = int'(clk_div); m_pend = -1;
         end else if (m_pend >= 0) begin
            m_div = m_pend; m_pend = -1;
         end
         if (en) begin
            m_run = 1; m_left = m_div;
         end
      end else begin
         if (m_left > 0) m_left--;
         else if (m_lvl) begin m_lvl = 0; m_left = m_div; end
         else if (en)    begin m_lvl = 1; m_left = m_div; end
         else m_run = 0;
         if (clk_div_valid) m_pend = int'(clk_div);
      end
   endtask

   task automatic cyc();
      bit er, ef;
      @(negedge clk);
      er = !rst && m_run && m_left == 0 && !m_lvl && en;
      ef = !rst && m_run && m_left == 0 && m_lvl;
      chk("spi_clk",   32'(spi_clk),   32'(m_lvl));
      chk("running",   32'(running),   32'(m_run));
      chk("rise_edge", 32'(rise_edge), 32'(er));
      chk("fall_edge", 32'(fall_edge), 32'(ef));
      if (rise_edge === 1'b1) rq.push_back(cyc_n);
      if (fall_edge === 1'b1) fq.push_back(cyc_n);
      model_step();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic run_n(input int n);
      repeat (n) cyc();
   endtask

   task automatic wait_hi(input int lim);
      int k = 0;
      while (spi_clk !== 1'b1 && k < lim) begin cyc(); k++; end
      chk("wait_spi_clk_high", 32'(spi_clk), 32'd1);
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (running !== 1'b0 && k < lim) begin cyc(); k++; end
      chk("wait_running_low", 32'(running), 32'd0);
   endtask

   function automatic int qat(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; clk_div = 8'd0; clk_div_valid = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      run_n(2);
      rst = 1'b0;
      cyc();

      // div=2, en held: rise at T+3, fall at T+6, period 6
      clk_div = 8'd2; clk_div_valid = 1'b1; cyc(); clk_div_valid = 1'b0;
      en = 1'b1; t0 = cyc_n; rq.delete(); fq.delete();
      run_n(15);
      chk("first_rise_div2", qat(rq, 0), t0 + 3);
      chk("first_fall_div2", qat(fq, 0), t0 + 6);
      chk("rise_period_div2", qat(rq, 1) - qat(rq, 0), 6);

      // Strobe div=5 mid-run: period unchanged until stop, restart uses 5
      clk_div = 8'd5; clk_div_valid = 1'b1; cyc(); clk_div_valid = 1'b0;
      run_n(10); rq.delete();
      run_n(12);
      chk("period_held_6", qat(rq, 1) - qat(rq, 0), 6);
      en = 1'b0; wait_idle(20);
      en = 1'b1; t0 = cyc_n; rq.delete();
      run_n(8);
      chk("restart_rise_div5", qat(rq, 0), t0 + 6);

      // Drop en while spi_clk is high
      wait_hi(20);
      en = 1'b0; fq.delete();
      wait_idle(20);
      chk("fall_after_drop", 32'(fq.size()), 32'd1);
      chk("stop_low", 32'(spi_clk), 32'd0);

      // Reset while spi_clk high; div_q returns to 0
      en = 1'b1; wait_hi(30);
      rst = 1'b1; cyc();
      rst = 1'b0; en = 1'b0; cyc();
      chk("post_rst_clk", 32'(spi_clk), 32'd0);
      chk("post_rst_run", 32'(running), 32'd0);
      en = 1'b1; t0 = cyc_n; rq.delete();
      run_n(4);
      chk("rise_after_rst", qat(rq, 0), t0 + 1);
      en = 1'b0; wait_idle(10);

      // div=0, en for 5 cycles
      clk_div = 8'd0; clk_div_valid = 1'b1; cyc(); clk_div_valid = 1'b0;
      en = 1'b1; t0 = cyc_n; rq.delete(); fq.delete();
      run_n(5);
      en = 1'b0;
      run_n(4);
      chk("div0_rises", 32'(rq.size()), 32'd2);
      chk("div0_falls", 32'(fq.size()), 32'd2);
      chk("div0_last_fall", qat(fq, 1), t0 + 4);
      chk("div0_stopped", 32'(running), 32'd0);

      // en and strobe in the same IDLE cycle
      en = 1'b1; clk_div = 8'd4; clk_div_valid = 1'b1; t0 = cyc_n; rq.delete();
      cyc(); clk_div_valid = 1'b0;
      run_n(8);
      chk("same_cycle_div4", qat(rq, 0), t0 + 5);
      en = 1'b0; wait_idle(20);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) en = ~en;
         clk_div_valid = ($urandom_range(0, 9) == 0);
         clk_div       = 8'($urandom_range(0, 6));
         rst           = ($urandom_range(0, 149) == 0);
         cyc();
      end
      rst = 1'b0; en = 1'b0; clk_div_valid = 1'b0;
      wait_idle(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
